// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides: single-cycle logic/arith/shift ops
// and a WIDTH-cycle shift-add unsigned multiplier. Result and flags are registered and held until taken.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Illegal
);
    localparam logic [5:0] OP_SLL = 6'h00;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h18;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_CMP = 6'h2A;

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state_reg;
    logic [2*WIDTH-1:0]  prod_reg;
    logic [WIDTH-1:0]    mcand_reg;
    logic [CNTW-1:0]     cnt_reg;

    logic [WIDTH:0]      add_w, sub_w, sll_w, srl_w, partial;
    logic [2*WIDTH-1:0]  prod_step;
    logic [SHW-1:0]      shamt;
    logic [WIDTH-1:0]    alu_res;
    logic                alu_c, alu_v, alu_ill;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    assign shamt = B[SHW-1:0];
    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    // One extra bit on each shifter catches the last bit shifted out (naturally 0 for shamt 0).
    assign sll_w = {1'b0, A} << shamt;
    assign srl_w = {A, 1'b0} >> shamt;

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign partial   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    assign prod_step = {partial, prod_reg[WIDTH-1:1]};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_CMP: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: begin
                alu_res = sll_w[WIDTH-1:0];
                alu_c   = sll_w[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_w[WIDTH:1];
                alu_c   = srl_w[0];
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            prod_reg  <= '0;
            mcand_reg <= '0;
            cnt_reg   <= '0;
            Result    <= '0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            CarryOut  <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (ALUControl == OP_MUL) begin
                            mcand_reg <= A;
                            prod_reg  <= {{WIDTH{1'b0}}, B};
                            cnt_reg   <= CNTW'(WIDTH);
                            state_reg <= MUL;
                        end else begin
                            Result    <= alu_res;
                            Zero      <= (alu_res == '0);
                            Negative  <= alu_res[WIDTH-1];
                            CarryOut  <= alu_c;
                            Overflow  <= alu_v;
                            Illegal   <= alu_ill;
                            state_reg <= DONE;
                        end
                    end
                end
                MUL: begin
                    prod_reg <= prod_step;
                    cnt_reg  <= cnt_reg - CNTW'(1);
                    // The final step publishes straight from the step logic to save a cycle.
                    if (cnt_reg == CNTW'(1)) begin
                        Result    <= prod_step[WIDTH-1:0];
                        Zero      <= (prod_step[WIDTH-1:0] == '0);
                        Negative  <= prod_step[WIDTH-1];
                        CarryOut  <= 1'b0;
                        Overflow  <= |prod_step[2*WIDTH-1:WIDTH];
                        Illegal   <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance share clock and reset;
// expected results and flags {Zero,Negative,CarryOut,Overflow,Illegal} are hand-computed.
module tb_alu_seq;
    localparam logic [5:0] OP_SLL = 6'h00;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h18;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_CMP = 6'h2A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv32 = 1'b0, or32 = 1'b0, ir32, ov32;
    logic [31:0] a32 = '0, b32 = '0, r32;
    logic [5:0]  op32 = '0;
    logic        z32, n32, c32, v32, i32;

    logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8;
    logic [7:0]  a8 = '0, b8 = '0, r8;
    logic [5:0]  op8 = '0;
    logic        z8, n8, c8, v8, i8;

    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
        .ALUControl(op32), .out_valid(ov32), .out_ready(or32), .Result(r32),
        .Zero(z32), .Negative(n32), .CarryOut(c32), .Overflow(v32), .Illegal(i32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .ALUControl(op8), .out_valid(ov8), .out_ready(or8), .Result(r8),
        .Zero(z8), .Negative(n8), .CarryOut(c8), .Overflow(v8), .Illegal(i8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handoff with in_valid held high: the handoff edge must not start a new operation.
    task automatic drain32(input string tag);
        @(negedge clk);
        or32 = 1'b1; iv32 = 1'b1; op32 = OP_ADD;
        @(posedge clk); #1;
        or32 = 1'b0; iv32 = 1'b0;
        check({tag, "_ovlow"}, 64'(ov32), 64'd0);
        check({tag, "_irhigh"}, 64'(ir32), 64'd1);
    endtask

    task automatic drain8(input string tag);
        @(negedge clk);
        or8 = 1'b1; iv8 = 1'b1; op8 = OP_ADD;
        @(posedge clk); #1;
        or8 = 1'b0; iv8 = 1'b0;
        check({tag, "_ovlow"}, 64'(ov8), 64'd0);
        check({tag, "_irhigh"}, 64'(ir8), 64'd1);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [31:0] er, input logic [4:0] ef,
                         input int elat, input bit hold);
        int lat;
        @(negedge clk);
        a32 = a; b32 = b; op32 = op; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn %s A=%h B=%h op=%h Result=%h flags=%b latency=%0d",
                 tag, a, b, op, r32, {z32, n32, c32, v32, i32}, lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_res"}, 64'(r32), 64'(er));
        check({tag, "_flags"}, 64'({z32, n32, c32, v32, i32}), 64'(ef));
        if (!hold) drain32(tag);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] op, input logic [7:0] er, input logic [4:0] ef,
                        input int elat);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; op8 = op; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn %s A=%h B=%h op=%h Result=%h flags=%b latency=%0d",
                 tag, a, b, op, r8, {z8, n8, c8, v8, i8}, lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_res"}, 64'(r8), 64'(er));
        check({tag, "_flags"}, 64'({z8, n8, c8, v8, i8}), 64'(ef));
        drain8(tag);
    endtask

    initial begin
        @(posedge clk); #1;
        check("rst_ir32", 64'(ir32), 64'd1);
        check("rst_ov32", 64'(ov32), 64'd0);
        check("rst_res32", 64'(r32), 64'd0);
        check("rst_flags32", 64'({z32, n32, c32, v32, i32}), 64'd0);
        check("rst_ov8", 64'(ov8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hold the first result under backpressure while the inputs churn.
        run32("add", 32'd10, 32'd5, OP_ADD, 32'd15, 5'b00000, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; op32 = OP_SUB; iv32 = 1'b1;
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
        $display("txn backpressure Result=%h in_ready=%b out_valid=%b", r32, ir32, ov32);
        check("bp_res", 64'(r32), 64'd15);
        check("bp_flags", 64'({z32, n32, c32, v32, i32}), 64'd0);
        check("bp_ir", 64'(ir32), 64'd0);
        check("bp_ov", 64'(ov32), 64'd1);
        drain32("bp");

        run32("sub_neg", 32'd15, 32'd20, OP_SUB, 32'hFFFF_FFFB, 5'b01000, 1, 1'b0);
        run32("add_ovf", 32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 5'b01010, 1, 1'b0);
        run32("cmp_lt", 32'hFFFF_FFFF, 32'd1, OP_CMP, 32'd1, 5'b00000, 1, 1'b0);
        run32("sub_zero", 32'd5, 32'd5, OP_SUB, 32'd0, 5'b10100, 1, 1'b0);
        run32("xor", 32'h0000_F0F0, 32'h0000_FFFF, OP_XOR, 32'h0000_0F0F, 5'b00000, 1, 1'b0);
        run32("or", 32'h8000_0000, 32'd1, OP_OR, 32'h8000_0001, 5'b01000, 1, 1'b0);
        run32("illegal", 32'd7, 32'd9, 6'h3F, 32'd0, 5'b10001, 1, 1'b0);
        run32("sll", 32'h8000_0001, 32'd33, OP_SLL, 32'h0000_0002, 5'b00100, 1, 1'b0);
        run32("mul32", 32'h0001_0000, 32'h0000_8001, OP_MUL, 32'h8001_0000, 5'b01000, 33, 1'b0);
        run32("srl", 32'h8000_000F, 32'd4, OP_SRL, 32'h0800_0000, 5'b00100, 1, 1'b0);

        // Reset three cycles into a multiply.
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd7; op32 = OP_MUL; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstmul_ov", 64'(ov32), 64'd0);
        check("rstmul_res", 64'(r32), 64'd0);
        check("rstmul_ir", 64'(ir32), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn reset_mid_mul in_ready=%b out_valid=%b Result=%h", ir32, ov32, r32);
        check("rstmul_ir_after", 64'(ir32), 64'd1);
        check("rstmul_ov_after", 64'(ov32), 64'd0);
        run32("and", 32'hFF00_FF00, 32'h0F0F_0F0F, OP_AND, 32'h0F00_0F00, 5'b00000, 1, 1'b0);

        run8("mul8_ovf", 8'h10, 8'h10, OP_MUL, 8'h00, 5'b10010, 9);
        run8("mul8", 8'd12, 8'd11, OP_MUL, 8'd132, 5'b01000, 9);
        run8("add8_carry", 8'hFF, 8'h01, OP_ADD, 8'h00, 5'b10100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal range 8..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port ALUControl  input  6  opcode, encodings from defines.v (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP, plus OP_XOR, OP_SLL, OP_SRL, OP_MUL added to defines.v by this block).
REQ-009 SHALL have port out_valid  output  1  Result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port Result  output  WIDTH  registered result.
REQ-012 SHALL have ports Zero, Negative, CarryOut, Overflow, Illegal  output  1 each  registered flags.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept an operation on a rising edge with in_valid && in_ready, capturing A, B, ALUControl.
REQ-015 SHALL, for non-MUL ops, go IDLE->DONE on the accept edge; out_valid high in the following cycle (latency 1).
REQ-016 SHALL, for OP_MUL, go IDLE->MUL, run one shift-add step per cycle for WIDTH cycles, then enter DONE; out_valid first high WIDTH+1 cycles after accept.
REQ-017 SHALL hold Result and flags stable in DONE until out_valid && out_ready, then go DONE->IDLE on that edge.
REQ-018 SHALL NOT accept a new operation in the same cycle as a result handoff (no same-edge DONE->DONE); next accept earliest one cycle later.
REQ-019 SHALL ignore in_valid, A, B, ALUControl changes while in MUL or DONE.
REQ-020 ADD: Result=A+B mod 2^WIDTH; CarryOut=carry out of MSB; Overflow=signed overflow.
REQ-021 SUB: Result=A-B mod 2^WIDTH; CarryOut=1 when no borrow (A>=B unsigned); Overflow=signed overflow.
REQ-022 AND/OR/XOR: bitwise; CarryOut=0; Overflow=0.
REQ-023 CMP: Result=1 if signed A<B else 0 (zero-extended); CarryOut=0; Overflow=0.
REQ-024 SLL/SRL: logical shift of A by B[log2(WIDTH)-1:0]; B upper bits ignored; CarryOut=last bit shifted out (0 when shift amount 0); Overflow=0.
REQ-025 MUL: unsigned; Result=low WIDTH bits of A*B; Overflow=1 iff high WIDTH bits nonzero; CarryOut=0.
REQ-026 Zero=(Result==0) and Negative=Result[WIDTH-1] for every op.
REQ-027 Unrecognised opcode: Result=0, Illegal=1, Zero=1, other flags 0, latency 1; Illegal=0 for all legal ops.

Reset
REQ-028 SHALL, on rst high, immediately force state=IDLE, Result=0, all flags 0, out_valid=0, in_ready=1, multiplier registers cleared.
REQ-029 SHALL abandon any in-progress MUL or pending DONE result on reset with no output produced.
REQ-030 SHALL not accept an operation on an edge where rst is high; in_ready=1 from the first edge after rst falls.

Verification
REQ-031 ADD/SUB, WIDTH=32: A=10,B=5 OP_ADD -> Result=15, flags 0, out_valid 1 cycle after accept; A=15,B=20 OP_SUB -> Result=0xFFFFFFFB, Negative=1, CarryOut=0.
REQ-032 Overflow/CMP: A=0x7FFFFFFF,B=1 OP_ADD -> Result=0x80000000, Overflow=1, Negative=1; A=0xFFFFFFFF(-1),B=1 OP_CMP -> Result=1.
REQ-033 MUL, WIDTH=8: A=0x10,B=0x10 -> Result=0x00, Overflow=1, Zero=1, out_valid exactly 9 cycles after accept; A=12,B=11 -> Result=132, Overflow=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles after out_valid -> Result/flags unchanged, in_ready=0; out_ready=1 -> out_valid low and in_ready high the next cycle.
REQ-035 Reset mid-MUL: assert rst 3 cycles into MUL -> out_valid 0, Result 0, in_ready 1 after release; following OP_AND 0xFF00FF00 & 0x0F0F0F0F -> 0x0F000F00.
REQ-036 Illegal/shift: opcode 6'h3F -> Illegal=1, Result=0; OP_SLL A=0x80000001,B=33 -> shift 1, Result=0x00000002, CarryOut=1.
